// File: rtl/multicycle_control_fsm_if.sv
// Purpose : control bundle between the multicycle control unit and the datapath/ALU.
// Latency : wires only; no storage.
// Backpressure: none; the datapath must hold op/funct fields (IR) stable while an instruction is in flight.
//
// Signals:
//   op, funct3, funct7  instruction fields taken from the instruction register
//   zero                ALU zero flag, consumed for beq
//   pc_write .. state   strobes, mux selects, ALU op, trap flag and debug state from the control unit
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic [3:0] state;

  // Control unit side.
  modport master (
    input  op, funct3, funct7, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_control,
    output illegal, state
  );

  // Datapath side.
  modport slave (
    output op, funct3, funct7, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_control,
    input  illegal, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Purpose : control unit of the multicycle RISC-V core (fetch/decode/execute/memory/writeback sequencing).
// Latency : FETCH->FETCH is lw 5, sw 4, R/I 4, beq 3, jal 4 cycles; illegal encodings park in TRAP until reset.
// Backpressure: none; outputs are Moore from the state register except pc_write in BEQ, which follows zero.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; while low, strobes are forced off and FETCH selects are shown
//   ctl    master side of multicycle_control_fsm_if (instruction fields in, datapath controls out)
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_fsm_if.master ctl
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] out_state;

  logic       r_ok;
  logic [2:0] r_alu;
  logic       i_ok;
  logic [2:0] i_alu;

  logic       pc_write_c;
  logic       adr_src_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic [1:0] result_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] imm_src_c;
  logic [2:0] alu_control_c;
  logic       illegal_c;

  // R-type function decode; anything outside the table is illegal.
  always_comb begin : r_decode
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case ({ctl.funct7, ctl.funct3})
      {7'b0000000, 3'b000}: r_alu = ALU_ADD;
      {7'b0100000, 3'b000}: r_alu = ALU_SUB;
      {7'b0000000, 3'b111}: r_alu = ALU_AND;
      {7'b0000000, 3'b110}: r_alu = ALU_OR;
      {7'b0000000, 3'b010}: r_alu = ALU_SLT;
      {7'b0000001, 3'b000}: r_alu = ALU_MUL;
      default:              r_ok  = 1'b0;
    endcase
  end

  // I-type decode looks at funct3 only.
  always_comb begin : i_decode
    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case (ctl.funct3)
      3'b000:  i_alu = ALU_ADD;
      3'b111:  i_alu = ALU_AND;
      3'b110:  i_alu = ALU_OR;
      3'b010:  i_alu = ALU_SLT;
      default: i_ok  = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = r_ok ? S_EXECR : S_TRAP;
          OP_I:         state_d = i_ok ? S_EXECI : S_TRAP;
          OP_BEQ:       state_d = (ctl.funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      // Only lw/sw reach MEMADR, so sw is the only alternative to lw here.
      S_MEMADR:   state_d = (ctl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is asserted the selects show FETCH regardless of where the
  // register currently sits; the strobes are killed below.
  assign out_state = rst_n ? state_q : S_FETCH;

  // Output logic.
  always_comb begin : out_decode
    pc_write_c    = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    result_src_c  = 2'b00;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    alu_control_c = ALU_ADD;
    illegal_c     = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write_c   = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        pc_write_c   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = r_alu;
      end
      S_EXECI: begin
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b01;
        alu_control_c = i_alu;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = ALU_SUB;
        pc_write_c    = ctl.zero;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
    end
  end

  // Immediate format depends on the opcode alone, in every state.
  always_comb begin : imm_decode
    imm_src_c = 2'b00;
    case (ctl.op)
      OP_SW:   imm_src_c = 2'b01;
      OP_BEQ:  imm_src_c = 2'b10;
      OP_JAL:  imm_src_c = 2'b11;
      default: imm_src_c = 2'b00;
    endcase
  end

  assign ctl.pc_write    = pc_write_c;
  assign ctl.adr_src     = adr_src_c;
  assign ctl.mem_write   = mem_write_c;
  assign ctl.ir_write    = ir_write_c;
  assign ctl.reg_write   = reg_write_c;
  assign ctl.result_src  = result_src_c;
  assign ctl.alu_src_a   = alu_src_a_c;
  assign ctl.alu_src_b   = alu_src_b_c;
  assign ctl.imm_src     = imm_src_c;
  assign ctl.alu_control = alu_control_c;
  assign ctl.illegal     = illegal_c;
  assign ctl.state       = state_q;

endmodule
